// File: rtl/stopwatch_bcd_counter_pkg.sv
// Shared definitions for the stopwatch timekeeping core: FSM encoding,
// BCD digit limits and the default tick divider.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam logic [3:0] DIG_MAX9 = 4'd9;
  localparam logic [3:0] DIG_MAX5 = 4'd5;

  localparam int TICK_DIV_DEFAULT = 1_000_000;

endpackage

// File: rtl/stopwatch_bcd_counter_bcd_digit.sv
// One BCD digit of the cascade: counts 0..MAX on inc, wraps to 0 and
// reports carry when incremented at MAX.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = DIG_MAX9
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = inc & (q == MAX);

  // Digit register; anything at or above MAX wraps so the range can never be left.
  always_ff @(posedge clk_100MHz) begin
    if (reset || clr) begin
      q <= 4'd0;
    end else if (inc) begin
      q <= (q >= MAX) ? 4'd0 : q + 4'd1;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch core: button conditioning, run/pause/clear FSM, 1/100 s
// prescaler and the eight-digit HH:MM:SS.cc BCD cascade.
module stopwatch_bcd_counter
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int PRESC_W  = 20
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] hr_10s,
  output logic [3:0] hr_1s,
  output logic [3:0] min_10s,
  output logic [3:0] min_1s,
  output logic [3:0] sec_10s,
  output logic [3:0] sec_1s,
  output logic [3:0] sec100_10s,
  output logic [3:0] sec100_1s,
  output logic       running,
  output logic       tick,
  output logic       overflow
);

  logic ss_sync1, ss_sync2, ss_prev;
  logic clr_sync1, clr_sync2, clr_prev;
  logic ss_event, clr_event;

  sw_state_t state, state_next;

  logic [PRESC_W-1:0] presc;
  logic               presc_wrap;
  logic               inc_en;
  logic [7:0]         carry;

  // Two-flop synchronizers followed by a previous-value flop for edge detection.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      ss_sync1  <= 1'b0;
      ss_sync2  <= 1'b0;
      ss_prev   <= 1'b0;
      clr_sync1 <= 1'b0;
      clr_sync2 <= 1'b0;
      clr_prev  <= 1'b0;
    end else begin
      ss_sync1  <= start_stop;
      ss_sync2  <= ss_sync1;
      ss_prev   <= ss_sync2;
      clr_sync1 <= clear;
      clr_sync2 <= clr_sync1;
      clr_prev  <= clr_sync2;
    end
  end

  assign ss_event  = ss_sync2 & ~ss_prev;
  assign clr_event = clr_sync2 & ~clr_prev;

  // Next-state logic; a clear event takes priority over start/stop.
  always_comb begin
    state_next = state;
    if (clr_event) begin
      state_next = IDLE;
    end else if (ss_event) begin
      case (state)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end else begin
      state_next = state;
    end
  end

  assign presc_wrap = (state == RUN) && (presc == PRESC_W'(TICK_DIV - 1));
  // A tick on the same edge as a start/stop event still counts; clear discards it.
  assign inc_en     = presc_wrap & ~clr_event;

  // State register, prescaler and the registered status outputs.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state    <= IDLE;
      presc    <= '0;
      running  <= 1'b0;
      tick     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == RUN);
      if (clr_event) begin
        presc    <= '0;
        tick     <= 1'b0;
        overflow <= 1'b0;
      end else if (state == RUN) begin
        presc    <= presc_wrap ? '0 : presc + PRESC_W'(1);
        tick     <= presc_wrap;
        overflow <= overflow | carry[7];
      end else begin
        presc    <= presc;
        tick     <= 1'b0;
        overflow <= overflow;
      end
    end
  end

  bcd_digit #(.MAX(DIG_MAX9)) u_sec100_1s (
    .clk_100MHz(clk_100MHz), .reset(reset), .clr(clr_event),
    .inc(inc_en), .q(sec100_1s), .carry(carry[0])
  );

  bcd_digit #(.MAX(DIG_MAX9)) u_sec100_10s (
    .clk_100MHz(clk_100MHz), .reset(reset), .clr(clr_event),
    .inc(carry[0]), .q(sec100_10s), .carry(carry[1])
  );

  bcd_digit #(.MAX(DIG_MAX9)) u_sec_1s (
    .clk_100MHz(clk_100MHz), .reset(reset), .clr(clr_event),
    .inc(carry[1]), .q(sec_1s), .carry(carry[2])
  );

  bcd_digit #(.MAX(DIG_MAX5)) u_sec_10s (
    .clk_100MHz(clk_100MHz), .reset(reset), .clr(clr_event),
    .inc(carry[2]), .q(sec_10s), .carry(carry[3])
  );

  bcd_digit #(.MAX(DIG_MAX9)) u_min_1s (
    .clk_100MHz(clk_100MHz), .reset(reset), .clr(clr_event),
    .inc(carry[3]), .q(min_1s), .carry(carry[4])
  );

  bcd_digit #(.MAX(DIG_MAX5)) u_min_10s (
    .clk_100MHz(clk_100MHz), .reset(reset), .clr(clr_event),
    .inc(carry[4]), .q(min_10s), .carry(carry[5])
  );

  bcd_digit #(.MAX(DIG_MAX9)) u_hr_1s (
    .clk_100MHz(clk_100MHz), .reset(reset), .clr(clr_event),
    .inc(carry[5]), .q(hr_1s), .carry(carry[6])
  );

  bcd_digit #(.MAX(DIG_MAX9)) u_hr_10s (
    .clk_100MHz(clk_100MHz), .reset(reset), .clr(clr_event),
    .inc(carry[6]), .q(hr_10s), .carry(carry[7])
  );

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter: one instance with TICK_DIV=4 for
// latency/pause/clear behaviour, one with TICK_DIV=1 for the digit cascade.
module tb_stopwatch_bcd_counter;

  logic clk;
  int   total;
  int   bad;

  logic rst4, ss4, clr4;
  logic [3:0] h10_4, h1_4, m10_4, m1_4, s10_4, s1_4, c10_4, c1_4;
  logic run4, tick4, ovf4;
  logic [31:0] d4;

  logic rst1, ss1, clr1;
  logic [3:0] h10_1, h1_1, m10_1, m1_1, s10_1, s1_1, c10_1, c1_1;
  logic run1, tick1, ovf1;
  logic [31:0] d1;

  logic [31:0] fv;

  assign d4 = {h10_4, h1_4, m10_4, m1_4, s10_4, s1_4, c10_4, c1_4};
  assign d1 = {h10_1, h1_1, m10_1, m1_1, s10_1, s1_1, c10_1, c1_1};

  stopwatch_bcd_counter #(.TICK_DIV(4), .PRESC_W(20)) dut4 (
    .clk_100MHz(clk), .reset(rst4), .start_stop(ss4), .clear(clr4),
    .hr_10s(h10_4), .hr_1s(h1_4), .min_10s(m10_4), .min_1s(m1_4),
    .sec_10s(s10_4), .sec_1s(s1_4), .sec100_10s(c10_4), .sec100_1s(c1_4),
    .running(run4), .tick(tick4), .overflow(ovf4)
  );

  stopwatch_bcd_counter #(.TICK_DIV(1), .PRESC_W(20)) dut1 (
    .clk_100MHz(clk), .reset(rst1), .start_stop(ss1), .clear(clr1),
    .hr_10s(h10_1), .hr_1s(h1_1), .min_10s(m10_1), .min_1s(m1_1),
    .sec_10s(s10_1), .sec_1s(s1_1), .sec100_10s(c10_1), .sec100_1s(c1_1),
    .running(run1), .tick(tick1), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Preload the TICK_DIV=1 digits from fv while the instance is not counting.
  task automatic load_digits1();
    force dut1.u_hr_10s.q     = fv[31:28];
    force dut1.u_hr_1s.q      = fv[27:24];
    force dut1.u_min_10s.q    = fv[23:20];
    force dut1.u_min_1s.q     = fv[19:16];
    force dut1.u_sec_10s.q    = fv[15:12];
    force dut1.u_sec_1s.q     = fv[11:8];
    force dut1.u_sec100_10s.q = fv[7:4];
    force dut1.u_sec100_1s.q  = fv[3:0];
    step(2);
    release dut1.u_hr_10s.q;
    release dut1.u_hr_1s.q;
    release dut1.u_min_10s.q;
    release dut1.u_min_1s.q;
    release dut1.u_sec_10s.q;
    release dut1.u_sec_1s.q;
    release dut1.u_sec100_10s.q;
    release dut1.u_sec100_1s.q;
    step(1);
  endtask

  task automatic test_reset();
    rst4 = 1'b1; ss4 = 1'b0; clr4 = 1'b0;
    rst1 = 1'b1; ss1 = 1'b0; clr1 = 1'b0;
    step(2);
    rst4 = 1'b0; rst1 = 1'b0;
    total++; if (d4 !== 32'h0) begin bad++; $display("FAIL reset_digits4 got=%h exp=%h", d4, 32'h0); end
    total++; if ({run4, tick4, ovf4} !== 3'b000) begin bad++; $display("FAIL reset_flags4 got=%b exp=000", {run4, tick4, ovf4}); end
    total++; if (d1 !== 32'h0) begin bad++; $display("FAIL reset_digits1 got=%h exp=%h", d1, 32'h0); end
    total++; if ({run1, tick1, ovf1} !== 3'b000) begin bad++; $display("FAIL reset_flags1 got=%b exp=000", {run1, tick1, ovf1}); end
  endtask

  task automatic test_start();
    int ticks;
    ss4 = 1'b1;
    step(2);
    total++; if (run4 !== 1'b0) begin bad++; $display("FAIL start_early got=%b exp=0", run4); end
    step(1);
    total++; if (run4 !== 1'b1) begin bad++; $display("FAIL start_latency got=%b exp=1", run4); end
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (i == 6) ss4 = 1'b0;
      ticks += int'(tick4);
    end
    total++; if (ticks !== 10) begin bad++; $display("FAIL start_ticks got=%0d exp=10", ticks); end
    total++; if (d4 !== 32'h0000_0010) begin bad++; $display("FAIL start_digits got=%h exp=%h", d4, 32'h0000_0010); end
    total++; if (run4 !== 1'b1) begin bad++; $display("FAIL start_single_toggle got=%b exp=1", run4); end
  endtask

  task automatic test_pause_resume();
    int ticks;
    step(3);
    ss4 = 1'b1;
    step(3);
    total++; if (run4 !== 1'b0) begin bad++; $display("FAIL pause_running got=%b exp=0", run4); end
    total++; if (d4 !== 32'h0000_0011) begin bad++; $display("FAIL pause_digits got=%h exp=%h", d4, 32'h0000_0011); end
    ss4 = 1'b0;
    ticks = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      ticks += int'(tick4);
    end
    total++; if (ticks !== 0) begin bad++; $display("FAIL pause_ticks got=%0d exp=0", ticks); end
    total++; if (d4 !== 32'h0000_0011) begin bad++; $display("FAIL pause_frozen got=%h exp=%h", d4, 32'h0000_0011); end
    ss4 = 1'b1;
    step(3);
    total++; if ({run4, tick4} !== 2'b10) begin bad++; $display("FAIL resume_rise got=%b exp=10", {run4, tick4}); end
    step(1);
    total++; if (tick4 !== 1'b0) begin bad++; $display("FAIL resume_tick_early got=%b exp=0", tick4); end
    step(1);
    total++; if (tick4 !== 1'b1) begin bad++; $display("FAIL resume_tick got=%b exp=1", tick4); end
    total++; if (d4 !== 32'h0000_0012) begin bad++; $display("FAIL resume_digits got=%h exp=%h", d4, 32'h0000_0012); end
  endtask

  task automatic test_held_level();
    step(20);
    total++; if (run4 !== 1'b1) begin bad++; $display("FAIL held_level_running got=%b exp=1", run4); end
    total++; if (d4 !== 32'h0000_0017) begin bad++; $display("FAIL held_level_digits got=%h exp=%h", d4, 32'h0000_0017); end
  endtask

  task automatic test_simultaneous();
    ss4 = 1'b0;
    step(2);
    ss4 = 1'b1; clr4 = 1'b1;
    step(2);
    total++; if (run4 !== 1'b1) begin bad++; $display("FAIL simul_early got=%b exp=1", run4); end
    step(1);
    total++; if (d4 !== 32'h0) begin bad++; $display("FAIL simul_digits got=%h exp=%h", d4, 32'h0); end
    total++; if ({run4, tick4, ovf4} !== 3'b000) begin bad++; $display("FAIL simul_flags got=%b exp=000", {run4, tick4, ovf4}); end
    ss4 = 1'b0; clr4 = 1'b0;
    step(3);
    ss4 = 1'b1;
    step(3);
    total++; if (run4 !== 1'b1) begin bad++; $display("FAIL simul_restart got=%b exp=1", run4); end
    step(4);
    total++; if ({tick4, d4} !== {1'b1, 32'h0000_0001}) begin bad++; $display("FAIL simul_from_idle got=%b/%h exp=1/%h", tick4, d4, 32'h0000_0001); end
  endtask

  task automatic test_reset_midrun();
    step(10);
    ss4 = 1'b0;
    step(1);
    rst4 = 1'b1;
    step(1);
    rst4 = 1'b0;
    total++; if (d4 !== 32'h0) begin bad++; $display("FAIL midrun_reset_digits got=%h exp=%h", d4, 32'h0); end
    total++; if ({run4, tick4, ovf4} !== 3'b000) begin bad++; $display("FAIL midrun_reset_flags got=%b exp=000", {run4, tick4, ovf4}); end
    step(5);
    total++; if ({run4, d4} !== {1'b0, 32'h0}) begin bad++; $display("FAIL midrun_reset_hold got=%b/%h exp=0/0", run4, d4); end
  endtask

  task automatic test_carry();
    ss1 = 1'b1;
    step(3);
    step(6000);
    total++; if (d1 !== 32'h0001_0000) begin bad++; $display("FAIL carry_minute got=%h exp=%h", d1, 32'h0001_0000); end
    total++; if (tick1 !== 1'b1) begin bad++; $display("FAIL carry_tick got=%b exp=1", tick1); end
    ss1 = 1'b0;
    step(2);
    ss1 = 1'b1;
    step(3);
    total++; if ({run1, d1} !== {1'b0, 32'h0001_0005}) begin bad++; $display("FAIL tick_with_pause got=%b/%h exp=0/%h", run1, d1, 32'h0001_0005); end
  endtask

  task automatic test_hour_carry();
    fv = 32'h0059_5999;
    load_digits1();
    total++; if (d1 !== 32'h0059_5999) begin bad++; $display("FAIL hour_preload got=%h exp=%h", d1, 32'h0059_5999); end
    ss1 = 1'b0;
    step(2);
    ss1 = 1'b1;
    step(3);
    total++; if ({run1, tick1, d1} !== {2'b10, 32'h0059_5999}) begin bad++; $display("FAIL hour_resume got=%b/%h exp=10/%h", {run1, tick1}, d1, 32'h0059_5999); end
    step(1);
    total++; if (d1 !== 32'h0100_0000) begin bad++; $display("FAIL hour_carry got=%h exp=%h", d1, 32'h0100_0000); end
    clr1 = 1'b1;
    step(3);
    total++; if ({run1, d1} !== {1'b0, 32'h0}) begin bad++; $display("FAIL clear_run got=%b/%h exp=0/0", run1, d1); end
    clr1 = 1'b0;
  endtask

  task automatic test_wrap();
    fv = 32'h9959_5999;
    load_digits1();
    ss1 = 1'b0;
    step(2);
    ss1 = 1'b1;
    step(3);
    total++; if ({run1, ovf1, d1} !== {2'b10, 32'h9959_5999}) begin bad++; $display("FAIL wrap_pre got=%b/%h exp=10/%h", {run1, ovf1}, d1, 32'h9959_5999); end
    step(1);
    total++; if (d1 !== 32'h0) begin bad++; $display("FAIL wrap_digits got=%h exp=%h", d1, 32'h0); end
    total++; if ({run1, tick1, ovf1} !== 3'b111) begin bad++; $display("FAIL wrap_flags got=%b exp=111", {run1, tick1, ovf1}); end
    step(5);
    total++; if ({ovf1, d1} !== {1'b1, 32'h0000_0005}) begin bad++; $display("FAIL wrap_sticky got=%b/%h exp=1/%h", ovf1, d1, 32'h0000_0005); end
    clr1 = 1'b1;
    step(3);
    total++; if ({run1, ovf1, d1} !== {2'b00, 32'h0}) begin bad++; $display("FAIL wrap_clear got=%b/%h exp=00/0", {run1, ovf1}, d1); end
    clr1 = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    fv    = 32'h0;
    test_reset();
    test_start();
    test_pause_resume();
    test_held_level();
    test_simultaneous();
    test_reset_midrun();
    test_carry();
    test_hour_carry();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
